// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 slave.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 8;
    localparam int SPI_CNT_BITS   = $clog2(SPI_FRAME_BITS);

    // Byte sent on MISO when the TX buffer is empty at a frame load.
    localparam logic [SPI_FRAME_BITS-1:0] SPI_IDLE_FILL = 8'h00;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    // MSB-first receive shift: the newest bit enters at the LSB.
    function automatic logic [SPI_FRAME_BITS-1:0] shift_in(
        input logic [SPI_FRAME_BITS-1:0] sr,
        input logic                      bit_in
    );
        return {sr[SPI_FRAME_BITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Three-stage synchronizer for one asynchronous SPI pin.
// Stages 1-2 resolve metastability; stage 3 is the delayed copy used for
// edge detection, so the level and both edge pulses come from stage 2.
module spi_slave_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Shift the pin through the synchronizer chain every clock.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour and no race is simulated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  =  sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: 8-bit MSB-first frames, one-byte TX buffer, byte-wide
// client interface. All pins are oversampled on clk.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the sticky
// rx_overrun flag (set when a byte completes before the previous one was
// acknowledged with rd_rx).
module spi_slave
    import spi_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SPI_FRAME_BITS-1:0] din,
    input  logic                      wr_sd,
    output logic                      tx_ready,
    input  logic                      rd_rx,
    output logic [SPI_FRAME_BITS-1:0] dout,
    output logic                      rx_valid,
    output logic                      spi_done_tick,
    output logic                      spi_idle,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      spi_ss_n,
    output logic                      spi_miso
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic                      rx_overrun
`endif
);

    localparam logic [SPI_CNT_BITS-1:0] CNT_LAST = SPI_CNT_BITS'(SPI_FRAME_BITS - 1);
    localparam logic [SPI_CNT_BITS-1:0] CNT_ZERO = '0;

    // Synchronized pins and edge pulses
    logic sclk_rise, sclk_fall, sclk_level;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level, ss_rise, ss_fall;

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .async_i(spi_clk),
        .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .async_i(spi_mosi),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // Chip select idles high, so its chain resets high to avoid a false ss_fall.
    spi_slave_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .async_i(spi_ss_n),
        .level_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_state_e                state_q, state_d;
    logic [SPI_CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                      started_q, started_d;   // a rise has been seen this frame
    logic [SPI_FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_FRAME_BITS-1:0] tx_buf_q, tx_buf_d;
    logic                      tx_ready_q, tx_ready_d;
    logic [SPI_FRAME_BITS-1:0] dout_q, dout_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      tick_q, tick_d;
    logic                      miso_q, miso_d;
    logic                      frame_load;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                      overrun_q, overrun_d;
`endif

    // Next-state logic: FSM transitions, bit counter, shift registers, buffers.
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        started_d  = started_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        dout_d     = dout_q;
        rx_valid_d = rx_valid_q;
        tick_d     = 1'b0;
        frame_load = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_d  = overrun_q;
`endif

        // Client write into an empty buffer; writes to a full buffer are dropped.
        if (wr_sd && tx_ready_q) begin
            tx_buf_d   = din;
            tx_ready_d = 1'b0;
        end

        // Acknowledge; a completion later in this block overrides it.
        if (rd_rx) begin
            rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_d  = 1'b0;
`endif
        end

        if (ss_rise) begin
            // Deselect aborts the frame; the TX buffer is left alone.
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            started_d = 1'b0;
            rx_sr_d   = '0;
            tx_sr_d   = '0;
        end else if (ss_fall) begin
            state_d    = SHIFT;
            cnt_d      = CNT_ZERO;
            started_d  = 1'b0;
            rx_sr_d    = '0;
            frame_load = 1'b1;
        end else if (state_q == SHIFT) begin
            if (sclk_rise) begin
                rx_sr_d   = shift_in(rx_sr_q, mosi_level);
                cnt_d     = cnt_q + SPI_CNT_BITS'(1);
                started_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    dout_d     = shift_in(rx_sr_q, mosi_level);
                    tick_d     = 1'b1;
                    rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
                    if (rx_valid_q && !rd_rx) begin
                        overrun_d = 1'b1;
                    end
`endif
                end
            end else if (sclk_fall) begin
                if (cnt_q != CNT_ZERO) begin
                    tx_sr_d = {tx_sr_q[SPI_FRAME_BITS-2:0], 1'b0};
                end else if (started_q) begin
                    // 8th fall: reload for a back-to-back byte. Falls before
                    // the first rise of a frame are spurious and ignored.
                    frame_load = 1'b1;
                end
            end
        end

        if (frame_load) begin
            if (!tx_ready_q) begin
                // Buffer full: send it; a same-cycle write refills the buffer.
                tx_sr_d = tx_buf_q;
                if (wr_sd) begin
                    tx_buf_d   = din;
                    tx_ready_d = 1'b0;
                end else begin
                    tx_ready_d = 1'b1;
                end
            end else begin
                // Buffer empty: a same-cycle write bypasses straight to the shifter.
                tx_sr_d    = wr_sd ? din : SPI_IDLE_FILL;
                tx_buf_d   = tx_buf_q;
                tx_ready_d = 1'b1;
            end
        end

        // MISO follows the shifter one cycle later; driven low while idle.
        miso_d = (state_q == SHIFT) ? tx_sr_q[SPI_FRAME_BITS-1] : 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            started_q  <= 1'b0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            dout_q     <= '0;
            rx_valid_q <= 1'b0;
            tick_q     <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            started_q  <= started_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            dout_q     <= dout_d;
            rx_valid_q <= rx_valid_d;
            tick_q     <= tick_d;
            miso_q     <= miso_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    // Sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign rx_overrun = overrun_q;
`endif

    assign tx_ready      = tx_ready_q;
    assign dout          = dout_q;
    assign rx_valid      = rx_valid_q;
    assign spi_done_tick = tick_q;
    assign spi_idle      = (state_q == IDLE);
    assign spi_miso      = miso_q;

    // MOSI edges and the SCLK level are not needed by the mode-0 datapath.
    logic unused_sync;
    assign unused_sync = mosi_rise ^ mosi_fall ^ sclk_level ^ ss_level;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (mode 0: SCLK idles low, data sampled on rising edge, shifted on falling edge, MSB first, 8-bit frames). It is the far end of the team's SPI master: it receives MOSI bytes and returns MISO bytes from a one-byte transmit buffer. It sits between the board SPI pins and an internal byte-wide client (register file or FIFO). All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
- No parameters. Frame width is fixed at 8.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `din` in 8: byte to transmit on MISO.
- `wr_sd` in 1: one-cycle strobe that writes `din` into the TX buffer.
- `tx_ready` out 1: TX buffer empty.
- `rd_rx` in 1: one-cycle strobe that acknowledges `dout` and clears `rx_valid`.
- `dout` out 8: last received byte.
- `rx_valid` out 1: `dout` holds an unacknowledged byte.
- `spi_done_tick` out 1: one-cycle pulse when a byte completes.
- `spi_idle` out 1: slave not selected.
- `spi_clk`, `spi_mosi`, `spi_ss_n` in 1 each: SPI pins; `spi_ss_n` is active low.
- `spi_miso` out 1: serial data to the master.
- `rx_overrun` out 1: present only with `SPI_SLAVE_OVERRUN_EN`; see Configuration.

## Operation
- Every SPI input passes through a 2-FF synchronizer. Edges are detected by comparing the 2nd stage against a 3rd registered stage, which yields `sclk_rise`, `sclk_fall`, `ss_fall` and `ss_rise` pulses.
- FSM has two states:
  - `idle`: `spi_ss_n` high. `spi_idle`=1, `spi_miso`=0.
  - `shift`: slave selected.
- Transitions:
  - `ss_fall`: go to `shift`, clear the bit counter, perform a frame load.
  - `ss_rise` in any state: go to `idle` and abort. Counter clears, partial RX bits are discarded, no tick, the TX shift register is discarded, the TX buffer is untouched.
- Frame load:
  - If the TX buffer is full, copy it to the TX shift register and set `tx_ready`=1.
  - If the buffer is empty, load 8'h00.
  - `spi_miso` = TX shift register bit 7.
- `sclk_rise` in `shift`:
  - RX shift register becomes {rx[6:0], mosi}; bit counter increments (3 bits, wraps 7→0).
  - On the 8th rise (counter 7→0): `dout` <= the assembled byte, `spi_done_tick`=1, `rx_valid`=1.
- `sclk_fall` in `shift`:
  - Counter ≠ 0: shift TX left, filling 0.
  - Counter == 0 (8th fall of a frame): frame load for the next back-to-back byte.
  - Falls while the counter is 0 before any rise in the frame (spurious) are ignored.
- `wr_sd` handling:
  - When `tx_ready`=1, the buffer takes `din` and `tx_ready`=0.
  - When `tx_ready`=0, the write is ignored.
  - `wr_sd` in the same cycle as a frame load with the buffer empty: `din` goes straight to the TX shift register and the buffer stays empty.
  - Buffer full in the same cycle: the old buffer content is loaded and `din` is captured into the buffer.
- `rd_rx` clears `rx_valid`. If it coincides with a byte completion, the completion wins (`rx_valid` stays 1).

## Timing
- Reset values:
  - `dout`=0, `rx_valid`=0, `tx_ready`=1, `spi_done_tick`=0, `spi_idle`=1, `spi_miso`=0, `rx_overrun`=0.
  - State `idle`; counter and all shift registers 0.
- Latency from an SPI pin edge to the internal action is 3 `clk` cycles. `spi_miso` is registered and updates on the cycle after the action.
- `spi_done_tick` and the `dout` update occur 3 cycles after the 8th SCLK rise, in the same cycle.
- Requirements on the SPI master:
  - Each SCLK high and low phase lasts at least 6 `clk` cycles.
  - `spi_ss_n` falls at least 6 `clk` cycles before the first rise.
  - MISO is guaranteed valid 4 cycles after any SCLK fall or `spi_ss_n` fall.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - Adds the `rx_overrun` output.
  - It is a sticky flag, set when a byte completes while `rx_valid`=1. `dout` is still overwritten.
  - It is cleared by `rd_rx` and by `reset`.
- Not defined: the port and its logic are absent; completions overwrite `dout` silently.

## Structure
- Package `spi_pkg`:
  - State typedef (`idle`, `shift`).
  - `SPI_FRAME_BITS`=8.
  - `SPI_IDLE_FILL`=8'h00.
- Sub-module `spi_slave_sync`: one instance per SPI input. It holds the 3-stage synchronizer and produces the level output plus rise and fall pulses.
- The FSM, counter, shift registers and buffers live in `spi_slave`.

## Test plan
- Reset mid-frame after 4 bits → every output returns to its reset value immediately; the next full frame is received correctly.
- `wr_sd` with `din`=8'hA5, then the master sends 8'h3C with 8-cycle SCLK phases → master receives 8'hA5; `dout`=8'h3C; one `spi_done_tick`; `rx_valid`=1; `tx_ready`=1 after the `ss_fall` load.
- Two back-to-back bytes with `spi_ss_n` held low and the buffer refilled with 8'h5A during the first byte → second MISO byte is 8'h5A; two ticks.
- Buffer empty at `ss_fall` → master receives 8'h00; a `wr_sd` in the same cycle as the load is sent instead.
- `spi_ss_n` raised after 5 rises → no tick, `dout` unchanged, FSM `idle`, `spi_miso`=0.
- With `SPI_SLAVE_OVERRUN_EN`, two frames without `rd_rx` → `rx_overrun`=1, `dout` = second byte; `rd_rx` clears both `rx_valid` and `rx_overrun`.
